// File: rtl/exe_if.sv
// Execute-stage bundle: operands and control from ID/EX, results and stall out.
interface exe_if;
   logic [31:0] PC_in;
   logic [31:0] Val1;
   logic [31:0] Val2;
   logic [31:0] Reg2;
   logic [3:0]  EXE_CMD;
   logic [4:0]  Dest;
   logic        Br_taken_in;
   logic        MEM_R_EN_in;
   logic        MEM_W_EN_in;
   logic        WB_EN_in;

   logic [31:0] ALU_result;
   logic [31:0] Br_addr;
   logic [31:0] Reg2_out;
   logic [4:0]  Dest_out;
   logic        Br_taken;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic        WB_EN;
   logic        stall;

   modport master (
      output PC_in, Val1, Val2, Reg2, EXE_CMD, Dest,
             Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
      input  ALU_result, Br_addr, Reg2_out, Dest_out,
             Br_taken, MEM_R_EN, MEM_W_EN, WB_EN, stall
   );

   modport slave (
      input  PC_in, Val1, Val2, Reg2, EXE_CMD, Dest,
             Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
      output ALU_result, Br_addr, Reg2_out, Dest_out,
             Br_taken, MEM_R_EN, MEM_W_EN, WB_EN, stall
   );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, branch target adder, optional 34-cycle
// shift-add multiplier enabled by defining MUL_UNIT_EN.
module exe_stage (
   input logic  clk,
   input logic  rst,
   exe_if.slave bus
);
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_MUL = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_NOR = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRA = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;

   logic [31:0] alu_comb;
   logic [4:0]  shamt;

   assign shamt = bus.Val2[4:0];

   // MUL is absent here on purpose: it only produces a value from the DONE state.
   always_comb begin
      alu_comb = '0;
      case (bus.EXE_CMD)
         OP_ADD:  alu_comb = bus.Val1 + bus.Val2;
         OP_SUB:  alu_comb = bus.Val1 - bus.Val2;
         OP_AND:  alu_comb = bus.Val1 & bus.Val2;
         OP_OR:   alu_comb = bus.Val1 | bus.Val2;
         OP_NOR:  alu_comb = ~(bus.Val1 | bus.Val2);
         OP_XOR:  alu_comb = bus.Val1 ^ bus.Val2;
         OP_SLL:  alu_comb = bus.Val1 << shamt;
         OP_SRA:  alu_comb = $unsigned($signed(bus.Val1) >>> shamt);
         OP_SRL:  alu_comb = bus.Val1 >> shamt;
         default: alu_comb = '0;
      endcase
   end

   assign bus.Br_addr  = bus.PC_in + {bus.Val2[29:0], 2'b00};
   assign bus.Br_taken = bus.Br_taken_in;
   assign bus.MEM_R_EN = bus.MEM_R_EN_in;
   assign bus.MEM_W_EN = bus.MEM_W_EN_in;
   assign bus.WB_EN    = bus.WB_EN_in;
   assign bus.Dest_out = bus.Dest;
   assign bus.Reg2_out = bus.Reg2;

`ifdef MUL_UNIT_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

   mul_state_t  state;
   logic [31:0] acc;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [4:0]  cnt;

   // Multiplicand shifts left while multiplier shifts right; bit 0 of b_q
   // selects whether the current partial product is added.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.EXE_CMD == OP_MUL) begin
               a_q   <= bus.Val1;
               b_q   <= bus.Val2;
               acc   <= '0;
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               if (b_q[0]) acc <= acc + a_q;
               a_q <= a_q << 1;
               b_q <= b_q >> 1;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Reset masks the IDLE-with-MUL request so stall is low throughout reset.
   assign bus.stall      = ~rst & ((state == BUSY) |
                                   ((state == IDLE) & (bus.EXE_CMD == OP_MUL)));
   assign bus.ALU_result = (state == DONE) ? acc : alu_comb;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;
   assign bus.stall      = 1'b0;
   assign bus.ALU_result = alu_comb;
`endif
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes expectations, a negedge
// monitor pops and compares ALU result, stall, branch target and pass-throughs.
module tb_exe_stage;
   localparam logic [3:0] C_ADD = 4'b0000;
   localparam logic [3:0] C_MUL = 4'b0001;
   localparam logic [3:0] C_SUB = 4'b0010;
   localparam logic [3:0] C_AND = 4'b0100;
   localparam logic [3:0] C_OR  = 4'b0101;
   localparam logic [3:0] C_NOR = 4'b0110;
   localparam logic [3:0] C_XOR = 4'b0111;
   localparam logic [3:0] C_SLL = 4'b1000;
   localparam logic [3:0] C_SRA = 4'b1001;
   localparam logic [3:0] C_SRL = 4'b1010;
   localparam logic [3:0] C_UND = 4'b0011;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   exe_if bus ();
   exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      string       name;
      logic [31:0] alu;
      logic        stall;
      logic [31:0] br;
      logic [40:0] pt;
   } exp_t;

   exp_t q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   seq       = 0;
   bit   finish_req = 1'b0;

   task automatic chk(input string name, input logic [40:0] act, input logic [40:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // One instruction per cycle; the expected response goes straight to the scoreboard.
   task automatic drive(input logic r, input logic [3:0] cmd, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] pc, input string name,
                        input logic [31:0] ealu, input logic estall);
      exp_t        e;
      logic [40:0] pt;
      logic [31:0] s;
      @(posedge clk);
      #1;
      seq++;
      s  = seq;
      pt = {s[3:0], s[4:0] ^ 5'h15, s[15:0], ~s[15:0]};
      rst         = r;
      bus.EXE_CMD = cmd;
      bus.Val1    = v1;
      bus.Val2    = v2;
      bus.PC_in   = pc;
      {bus.Br_taken_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in, bus.WB_EN_in,
       bus.Dest, bus.Reg2} = pt;
      e.name  = name;
      e.alu   = ealu;
      e.stall = estall;
      e.br    = pc + (v2 << 2);
      e.pt    = pt;
      q.push_back(e);
   endtask

`ifdef MUL_UNIT_EN
   task automatic mul_seq(input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] prod, input string name);
      drive(1'b0, C_MUL, v1, v2, 32'h40, {name, "_start"}, 32'h0, 1'b1);
      for (int i = 0; i < 32; i++)
         drive(1'b0, C_MUL, $urandom, $urandom, 32'h40, {name, "_busy"}, 32'h0, 1'b1);
      drive(1'b0, C_MUL, v1, v2, 32'h40, {name, "_done"}, prod, 1'b0);
   endtask
`endif

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.name, ".alu"},   {9'h0, bus.ALU_result}, {9'h0, e.alu});
         chk({e.name, ".stall"}, {40'h0, bus.stall},     {40'h0, e.stall});
         chk({e.name, ".br"},    {9'h0, bus.Br_addr},    {9'h0, e.br});
         chk({e.name, ".pass"},
             {bus.Br_taken, bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN, bus.Dest_out, bus.Reg2_out},
             e.pt);
      end else if (finish_req) begin
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      bus.EXE_CMD = C_ADD;
      bus.Val1 = '0; bus.Val2 = '0; bus.PC_in = '0; bus.Reg2 = '0; bus.Dest = '0;
      {bus.Br_taken_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in, bus.WB_EN_in} = '0;

      // During reset: comb outputs follow inputs, stall stays low even for MUL.
      drive(1'b1, C_ADD, 32'd2, 32'd3, 32'h0, "rst_add", 32'd5, 1'b0);
      drive(1'b1, C_MUL, 32'd5, 32'd7, 32'h8, "rst_mul", 32'd0, 1'b0);

      drive(1'b0, C_ADD, 32'h7FFFFFFF, 32'h1,   32'h10,  "add_wrap", 32'h80000000, 1'b0);
      drive(1'b0, C_SUB, 32'h0, 32'h1,          32'h20,  "sub_wrap", 32'hFFFFFFFF, 1'b0);
      drive(1'b0, C_SRA, 32'h80000000, 32'h4,   32'h0,   "sra",      32'hF8000000, 1'b0);
      drive(1'b0, C_SLL, 32'h3, 32'h21,         32'h0,   "sll_mask", 32'h6,        1'b0);
      drive(1'b0, C_SRL, 32'h80000000, 32'h4,   32'h0,   "srl",      32'h08000000, 1'b0);
      drive(1'b0, C_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h4, "and",  32'hF000F000, 1'b0);
      drive(1'b0, C_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h4, "or",   32'hFFF0FFF0, 1'b0);
      drive(1'b0, C_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h4, "nor",  32'h000F000F, 1'b0);
      drive(1'b0, C_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h4, "xor",  32'h0FF00FF0, 1'b0);
      drive(1'b0, C_UND, 32'h12345678, 32'h1,   32'h0,   "undef",    32'h0,        1'b0);
      drive(1'b0, C_ADD, 32'h0, 32'hFFFFFFFF,   32'h100, "br_neg",   32'hFFFFFFFF, 1'b0);

`ifdef MUL_UNIT_EN
      mul_seq(32'h00012345, 32'h00000010, 32'h00123450, "mul_a");
      drive(1'b0, C_ADD, 32'd1, 32'd1, 32'h0, "post_mul_add", 32'd2, 1'b0);

      mul_seq(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_neg");
      mul_seq(32'd3, 32'd5, 32'h0000000F, "mul_b2b");

      // Abort at BUSY cycle 10; no result may surface afterwards.
      drive(1'b0, C_MUL, 32'd7, 32'd9, 32'h0, "abort_start", 32'h0, 1'b1);
      for (int i = 0; i <= 10; i++)
         drive(1'b0, C_MUL, 32'd7, 32'd9, 32'h0, "abort_busy", 32'h0, 1'b1);
      drive(1'b1, C_ADD, 32'd10, 32'd20, 32'h0, "abort_rst", 32'h1E, 1'b0);
      for (int i = 0; i < 25; i++)
         drive(1'b0, C_ADD, 32'd10, 32'd20, 32'h0, "abort_add", 32'h1E, 1'b0);
      mul_seq(32'd6, 32'd7, 32'd42, "mul_after_abort");
`else
      drive(1'b0, C_MUL, 32'd3, 32'd5, 32'h0, "mul_off",  32'h0, 1'b0);
      drive(1'b0, C_MUL, 32'hFFFFFFFF, 32'h2, 32'h0, "mul_off2", 32'h0, 1'b0);
      drive(1'b0, C_ADD, 32'd3, 32'd5, 32'h0, "add_after", 32'd8, 1'b0);
`endif

      @(posedge clk);
      #1;
      finish_req = 1'b1;
   end
endmodule
